// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM encoding and width helper for the round-robin interrupt controller.
package irq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, SERVE = 2'd2, CLEAR = 2'd3} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first set bit of pend at or after ptr, wrapping; rotate, find-first-set, un-rotate.
module rr_picker import irq_pkg::*; #(
  parameter int N_CH = 4,
  localparam int IDW = clog2(N_CH)
) (
  input  logic [N_CH-1:0] pend,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);
  logic [N_CH-1:0] rot;
  logic [IDW-1:0]  off;
  always_comb begin
    rot = '0;
    off = '0;
    for (int i = 0; i < N_CH; i++) rot[i] = pend[IDW'((int'(ptr) + i) % N_CH)];
    for (int i = N_CH - 1; i >= 0; i--) off = rot[i] ? IDW'(i) : off;
    found = |pend;
    idx = IDW'((int'(ptr) + int'(off)) % N_CH);
  end
endmodule

// File: rtl/irq_rr_controller.sv
// irq_rr_controller: masks per-channel irqs, grants one channel at a time round-robin,
// waits for the CPU ack (or times out and masks the channel), then pulses its clear.
module irq_rr_controller import irq_pkg::*; #(
  parameter int N_CH = 4,
  parameter int ACK_TIMEOUT = 1024,
  parameter logic [N_CH-1:0] MASK_RST = '1,
  localparam int IDW = clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] irq_in,
  input  logic            mask_wr,
  input  logic [N_CH-1:0] mask_wdata,
  output logic [N_CH-1:0] mask_q,
  output logic            cpu_irq,
  output logic [IDW-1:0]  cpu_id,
  input  logic            cpu_ack,
  output logic [N_CH-1:0] clr,
  output logic            busy,
  output logic            timeout_err,
  input  logic            err_clr
);
  localparam int CW = clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(ACK_TIMEOUT - 1);
  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   cnt;
  logic [N_CH-1:0] pend;
  logic            found;
  logic [IDW-1:0]  idx;
  assign pend = irq_in & mask_q;
  assign busy = state != IDLE;
  rr_picker #(.N_CH(N_CH)) u_pick (.pend(pend), .ptr(ptr), .found(found), .idx(idx));
  // Later bit-write to mask_q overrides the whole-register load, so a timeout wins for cpu_id only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      mask_q      <= MASK_RST;
      cpu_irq     <= 1'b0;
      cpu_id      <= '0;
      clr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      clr <= '0;
      mask_q <= mask_wr ? mask_wdata : mask_q;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: state <= |pend ? ARB : IDLE;
        ARB: begin
          state   <= found ? SERVE : IDLE;
          cpu_id  <= found ? idx : cpu_id;
          cpu_irq <= found;
          cnt     <= '0;
        end
        SERVE: begin
          if (cpu_ack || cnt == CMAX) begin
            state   <= CLEAR;
            cpu_irq <= 1'b0;
            clr     <= {{(N_CH-1){1'b0}}, 1'b1} << cpu_id;
          end else cnt <= cnt + 1'b1;
          if (!cpu_ack && cnt == CMAX) begin
            mask_q[cpu_id] <= 1'b0;
            timeout_err    <= 1'b1;
          end
        end
        CLEAR: begin
          state <= IDLE;
          ptr   <= (cpu_id == IDW'(N_CH - 1)) ? '0 : cpu_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
